// File: rtl/dspctl_pkg.sv
// rtl/dspctl_pkg.sv - shared display constants, FSM encoding and cell layout
package dspctl_pkg;

   localparam int NROWS_DEF = 30;
   localparam int NCOLS_DEF = 80;

   localparam logic OP_CLEAR  = 1'b0;
   localparam logic OP_SCROLL = 1'b1;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_BUS_ACK  = 3'd1;
   localparam logic [2:0] ST_ENG_RD   = 3'd2;
   localparam logic [2:0] ST_ENG_WR   = 3'd3;
   localparam logic [2:0] ST_ENG_FILL = 3'd4;

   typedef struct packed {
      logic [7:0] attr;
      logic [7:0] chr;
   } cell_t;

   // First engine state of a cell: scroll copies from the row below except on the bottom row.
   function automatic logic [2:0] cell_state(input logic op, input logic is_last_row);
      return (op == OP_SCROLL && !is_last_row) ? ST_ENG_RD : ST_ENG_FILL;
   endfunction

endpackage

// File: rtl/dspcnt.sv
// rtl/dspcnt.sv - row-major cell counter for the fill/scroll engine
module dspcnt #(
   parameter int NROWS = 30,
   parameter int NCOLS = 80
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       adv,
   output logic [4:0] row,
   output logic [6:0] col,
   output logic [4:0] row_nxt,
   output logic       last
);

   localparam logic [4:0] LAST_ROW = 5'(NROWS - 1);
   localparam logic [6:0] LAST_COL = 7'(NCOLS - 1);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         row <= '0;
         col <= '0;
      end else if (adv) begin
         if (col == LAST_COL) begin
            col <= '0;
            row <= row + 5'd1;
         end else begin
            col <= col + 7'd1;
         end
      end
   end

   // Row the engine will be on after the current cell completes.
   assign row_nxt = (col == LAST_COL) ? row + 5'd1 : row;
   assign last    = (row == LAST_ROW) && (col == LAST_COL);

endmodule

// File: rtl/dspctl.sv
// rtl/dspctl.sv - display memory access controller: bus port plus clear/scroll engine
module dspctl import dspctl_pkg::*; #(
   parameter int NROWS = NROWS_DEF,
   parameter int NCOLS = NCOLS_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bus_stb,
   input  logic        bus_we,
   input  logic [4:0]  bus_row,
   input  logic [6:0]  bus_col,
   input  logic [15:0] bus_wr_data,
   output logic [15:0] bus_rd_data,
   output logic        bus_ack,
   input  logic        cmd_start,
   input  logic        cmd_op,
   input  logic [15:0] cmd_fill,
   output logic        busy,
   output logic        done,
   output logic [4:0]  mem_row,
   output logic [6:0]  mem_col,
   output logic [15:0] mem_wr_data,
   input  logic [15:0] mem_rd_data,
   output logic        mem_en,
   output logic        mem_wr
);

   localparam logic [4:0] LAST_ROW = 5'(NROWS - 1);

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic       op;
   cell_t      fill;
   logic [4:0] row;
   logic [4:0] row_nxt;
   logic [6:0] col;
   logic       last_cell;
   logic       start_ok;
   logic       cell_end;

   assign start_ok = cmd_start & ~busy;
   assign cell_end = (state == ST_ENG_WR) || (state == ST_ENG_FILL);

   dspcnt #(
      .NROWS(NROWS),
      .NCOLS(NCOLS)
   ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (start_ok),
      .adv    (cell_end),
      .row    (row),
      .col    (col),
      .row_nxt(row_nxt),
      .last   (last_cell)
   );

   // The bus is only let in at cell boundaries; IDLE doubles as the bus slot during a run.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (bus_stb)       state_nxt = ST_BUS_ACK;
            else if (busy)     state_nxt = cell_state(op, row == LAST_ROW);
            else if (start_ok) state_nxt = cell_state(cmd_op, LAST_ROW == 5'd0);
         end
         ST_BUS_ACK:  state_nxt = busy ? cell_state(op, row == LAST_ROW) : ST_IDLE;
         ST_ENG_RD:   state_nxt = ST_ENG_WR;
         ST_ENG_WR,
         ST_ENG_FILL: begin
            if (last_cell || bus_stb) state_nxt = ST_IDLE;
            else                      state_nxt = cell_state(op, row_nxt == LAST_ROW);
         end
         default:     state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         op    <= OP_CLEAR;
         fill  <= '0;
      end else begin
         state <= state_nxt;
         done  <= cell_end && last_cell;
         if (start_ok) begin
            busy <= 1'b1;
            op   <= cmd_op;
            fill <= cmd_fill;
         end else if (cell_end && last_cell) begin
            busy <= 1'b0;
         end
      end
   end

   always_comb begin
      mem_en      = 1'b0;
      mem_wr      = 1'b0;
      mem_row     = row;
      mem_col     = col;
      mem_wr_data = fill;
      case (state)
         ST_IDLE: begin
            if (bus_stb) begin
               mem_en      = 1'b1;
               mem_wr      = bus_we;
               mem_row     = bus_row;
               mem_col     = bus_col;
               mem_wr_data = bus_wr_data;
            end
         end
         ST_ENG_RD: begin
            mem_en  = 1'b1;
            mem_row = row + 5'd1;
         end
         ST_ENG_WR: begin
            mem_en      = 1'b1;
            mem_wr      = 1'b1;
            mem_wr_data = mem_rd_data;
         end
         ST_ENG_FILL: begin
            mem_en = 1'b1;
            mem_wr = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus_ack     = (state == ST_BUS_ACK);
   assign bus_rd_data = mem_rd_data;

endmodule

// File: tb/tb_dspctl.sv
// tb/tb_dspctl.sv - directed and randomized bench for dspctl with a behavioural display memory
module tb_dspctl;

   localparam int NR = 30;
   localparam int NC = 80;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        bus_stb = 1'b0;
   logic        bus_we = 1'b0;
   logic [4:0]  bus_row = '0;
   logic [6:0]  bus_col = '0;
   logic [15:0] bus_wr_data = '0;
   logic [15:0] bus_rd_data;
   logic        bus_ack;
   logic        cmd_start = 1'b0;
   logic        cmd_op = 1'b0;
   logic [15:0] cmd_fill = '0;
   logic        busy;
   logic        done;
   logic [4:0]  mem_row;
   logic [6:0]  mem_col;
   logic [15:0] mem_wr_data;
   logic [15:0] mem_rd_data;
   logic        mem_en;
   logic        mem_wr;

   logic [15:0] mem     [0:31][0:127];
   logic [15:0] exp_img [0:31][0:127];
   int n_vec = 0;
   int n_err = 0;

   dspctl dut (
      .clk        (clk),
      .rst        (rst),
      .bus_stb    (bus_stb),
      .bus_we     (bus_we),
      .bus_row    (bus_row),
      .bus_col    (bus_col),
      .bus_wr_data(bus_wr_data),
      .bus_rd_data(bus_rd_data),
      .bus_ack    (bus_ack),
      .cmd_start  (cmd_start),
      .cmd_op     (cmd_op),
      .cmd_fill   (cmd_fill),
      .busy       (busy),
      .done       (done),
      .mem_row    (mem_row),
      .mem_col    (mem_col),
      .mem_wr_data(mem_wr_data),
      .mem_rd_data(mem_rd_data),
      .mem_en     (mem_en),
      .mem_wr     (mem_wr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_wr) mem[mem_row][mem_col] <= mem_wr_data;
         mem_rd_data <= mem[mem_row][mem_col];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic bus_xfer(input logic we, input logic [4:0] r, input logic [6:0] c,
                           input logic [15:0] wd, output logic [15:0] rd, output int lat);
      @(posedge clk); #1;
      bus_stb = 1'b1; bus_we = we; bus_row = r; bus_col = c; bus_wr_data = wd;
      lat = 0;
      rd  = 'x;
      while (lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (bus_ack === 1'b1) begin
            rd = bus_rd_data;
            break;
         end
      end
      bus_stb = 1'b0;
   endtask

   task automatic bus_write(input int r, input int c, input logic [15:0] d);
      logic [15:0] rd;
      int lat;
      bus_xfer(1'b1, 5'(r), 7'(c), d, rd, lat);
      exp_img[r][c] = d;
      chk("wr_lat", lat, 1);
   endtask

   task automatic bus_read_chk(input string tag, input int r, input int c);
      logic [15:0] rd;
      int lat;
      bus_xfer(1'b0, 5'(r), 7'(c), 16'h0, rd, lat);
      chk({tag, "_lat"}, lat, 1);
      chk(tag, rd, exp_img[r][c]);
   endtask

   task automatic run_engine(input logic op, input logic [15:0] f, input bit poke,
                             output int cyc, output int dones);
      @(posedge clk); #1;
      cmd_start = 1'b1; cmd_op = op; cmd_fill = f;
      @(posedge clk); #1;
      cmd_start = 1'b0;
      cyc = 0;
      dones = 0;
      while (busy === 1'b1 && cyc < 20000) begin
         cyc++;
         if (poke && cyc == 100) begin
            cmd_start = 1'b1; cmd_op = ~op; cmd_fill = ~f;
         end else begin
            cmd_start = 1'b0;
         end
         @(posedge clk); #1;
         if (done === 1'b1) dones++;
      end
      cmd_start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done === 1'b1) dones++;
      end
   endtask

   task automatic model_clear(input logic [15:0] f);
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++) exp_img[r][c] = f;
   endtask

   task automatic model_scroll(input logic [15:0] f);
      for (int r = 0; r < NR - 1; r++)
         for (int c = 0; c < NC; c++) exp_img[r][c] = exp_img[r + 1][c];
      for (int c = 0; c < NC; c++) exp_img[NR - 1][c] = f;
   endtask

   task automatic check_image(input string tag);
      int bad = 0;
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++)
            if (mem[r][c] !== exp_img[r][c]) bad++;
      chk(tag, bad, 0);
   endtask

   initial begin
      int cyc, dones, n_acc, stb_cyc, m, dn;
      bit pending;
      logic [15:0] f;
      int ra [16];
      int ca [16];

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ack", bus_ack, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_wr", mem_wr, 0);
      rst = 1'b0;

      bus_write(3, 10, 16'h1F41);
      bus_read_chk("rd_3_10", 3, 10);

      for (int i = 0; i < 16; i++) begin
         ra[i] = $urandom_range(0, NR - 1);
         ca[i] = $urandom_range(0, NC - 1);
         bus_write(ra[i], ca[i], 16'($urandom));
      end
      for (int i = 15; i >= 0; i--) bus_read_chk("rnd_rd", ra[i], ca[i]);

      f = 16'($urandom);
      bus_write(31, 127, f);
      chk("oor_mem", mem[31][127], f);
      bus_read_chk("oor_rd", 31, 127);

      run_engine(1'b0, 16'h0720, 1'b1, cyc, dones);
      chk("clr_cycles", cyc, NR * NC);
      chk("clr_done", dones, 1);
      model_clear(16'h0720);
      check_image("clr_image");
      bus_read_chk("clr_0_0", 0, 0);
      bus_read_chk("clr_29_79", 29, 79);
      bus_read_chk("clr_15_40", 15, 40);

      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++) bus_write(r, c, {8'(r), 8'(c)});
      run_engine(1'b1, 16'h0720, 1'b0, cyc, dones);
      chk("scr_cycles", cyc, 2 * (NR - 1) * NC + NC);
      chk("scr_done", dones, 1);
      model_scroll(16'h0720);
      check_image("scr_image");
      bus_read_chk("scr_0_5", 0, 5);
      bus_read_chk("scr_28_79", 28, 79);
      bus_read_chk("scr_29_0", 29, 0);

      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++) bus_write(r, c, 16'($urandom));
      f = 16'($urandom);
      @(posedge clk); #1;
      cmd_start = 1'b1; cmd_op = 1'b1; cmd_fill = f;
      @(posedge clk); #1;
      cmd_start = 1'b0;
      cyc = 0; n_acc = 0; pending = 0; stb_cyc = 0;
      while (busy === 1'b1 && cyc < 20000) begin
         cyc++;
         if (pending && bus_ack === 1'b1) begin
            chk("dist_lat", (cyc - stb_cyc) <= 2, 1);
            bus_stb = 1'b0;
            pending = 0;
            n_acc++;
         end else if (!pending && cyc % 50 == 10 && cyc + 60 < 4720 + 2 * n_acc) begin
            bus_stb = 1'b1; bus_we = 1'b0;
            bus_row = 5'($urandom_range(0, NR - 1));
            bus_col = 7'($urandom_range(0, NC - 1));
            stb_cyc = cyc;
            pending = 1;
         end
         @(posedge clk); #1;
      end
      bus_stb = 1'b0;
      chk("dist_pending", pending, 0);
      chk("dist_done", done, 1);
      chk("dist_naccess", n_acc >= 80, 1);
      chk("dist_cycles", cyc, 2 * (NR - 1) * NC + NC + 2 * n_acc);
      model_scroll(f);
      check_image("dist_image");

      f = 16'($urandom);
      m = $urandom_range(200, 2000);
      @(posedge clk); #1;
      cmd_start = 1'b1; cmd_op = 1'b0; cmd_fill = f;
      @(posedge clk); #1;
      cmd_start = 1'b0;
      for (int k = 1; k < m; k++) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_mem_en", mem_en, 0);
      dn = (done === 1'b1) ? 1 : 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done === 1'b1) dn++;
      end
      chk("abort_no_done", dn, 0);
      for (int i = 0; i < m; i++) exp_img[i / NC][i % NC] = f;
      check_image("abort_image");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
